// File: rtl/bin2seg_scan_n.sv
// bin2seg_scan_n: binary word -> serial double-dabble BCD -> multiplexed common-anode 7-segment display
// Define LEADING_ZERO_BLANK_EN to blank digits above the most-significant non-zero digit.
module bin2seg_scan_n #(
  parameter int DATA_W   = 24,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              read_enable,
  input  logic [DATA_W-1:0] buff_out,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] anode,
  output logic [7:0]        cathode
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bcd_q, bcd_d, bcd_adj, disp_q, disp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_work_q, ovf_work_d, ovf_q, ovf_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [7:0]        cathode_q, cathode_d;
  logic [3:0]        digit;
  logic              blank, wrap;

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_work_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      scan_q     <= '0;
      idx_q      <= '0;
      anode_q    <= '1;
      cathode_q  <= 8'hFF;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_work_q <= ovf_work_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      cathode_q  <= cathode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_work_d = ovf_work_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    bcd_adj    = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    case (state_q)
      IDLE: if (read_enable) begin
        shreg_d    = buff_out;
        bcd_d      = '0;
        ovf_work_d = 1'b0;
        cnt_d      = CW'(DATA_W);
        state_d    = CONVERT;
      end
      CONVERT: begin
        // a carry out of the top nibble means the value no longer fits in DIGITS digits
        {bcd_d, shreg_d} = {bcd_adj[BW-2:0], shreg_q, 1'b0};
        ovf_work_d       = ovf_work_q | bcd_adj[BW-1];
        cnt_d            = cnt_q - 1'b1;
        state_d          = cnt_q == CW'(1) ? UPDATE : CONVERT;
      end
      UPDATE: begin
        disp_d  = bcd_q;
        ovf_d   = ovf_work_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign digit = disp_q[4*idx_q +: 4];
`ifdef LEADING_ZERO_BLANK_EN
  assign blank = idx_q != '0 && (disp_q >> (4*idx_q)) == '0;
`else
  assign blank = 1'b0;
`endif
  assign wrap      = scan_q == SW'(SCAN_DIV - 1);
  assign scan_d    = enable ? (wrap ? '0 : scan_q + 1'b1) : scan_q;
  assign idx_d     = enable && wrap ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
  assign anode_d   = enable ? ~(DIGITS'(1) << idx_q) : '1;
  assign cathode_d = !enable ? 8'hFF : ovf_q ? 8'hBF : blank ? 8'hFF : seg(digit);

  assign busy     = state_q != IDLE;
  assign overflow = ovf_q;
  assign anode    = anode_q;
  assign cathode  = cathode_q;
endmodule
